urv_clint_mh: RTL

Parametrised multi-hart core-local interruptor (CLINT) for the urv32 SoC. It holds a 64-bit `mtime` counter with a programmable prescaler, plus one `mtimecmp` and one `msip` per hart, all reached through the 32-bit memory request/response bus at the CLINT base address. It drives a registered timer-interrupt line (`mtip`) and a software-interrupt line (`msip`) to each hart. It supersedes the single-hart CLINT and adds the hart count, the prescaler, byte-masked writes and error responses.

---
 rtl/urv_clint_mh.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/urv_clint_mh.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | urv_clint_mh : multi-hart CLINT (prescaled 64-bit mtime, mtimecmp, msip)   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module urv_clint_mh #(
    parameter int NUM_HARTS = 1,
    parameter int TICK_DIV  = 1,
    parameter int ADDR_W    = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_req_vld,
    output logic                 mem_req_rdy,
    input  logic [ADDR_W-1:0]    mem_req_addr,
    input  logic                 mem_req_wen,
    input  logic [31:0]          mem_req_data,
    input  logic [3:0]           mem_req_mask,
    output logic                 mem_resp_vld,
    input  logic                 mem_resp_rdy,
    output logic [31:0]          mem_resp_data,
    output logic                 mem_resp_err,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip
);

    localparam int              c_pcnt_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pcnt_w-1:0] c_pcnt_max = c_pcnt_w'(TICK_DIV - 1);

    logic [c_pcnt_w-1:0]        pcnt_q, pcnt_d;
    logic [63:0]                mtime_q, mtime_d;
    logic [NUM_HARTS-1:0][63:0] mtimecmp_q, mtimecmp_d;
    logic [NUM_HARTS-1:0]       msip_q, msip_d;
    logic [NUM_HARTS-1:0]       mtip_q, mtip_d;
    logic                       resp_vld_q;
    logic [31:0]                resp_data_q;
    logic                       resp_err_q;

    logic        w_accept;
    logic        w_wr;
    logic        w_hit;
    logic        w_tick;
    logic        w_mtime_wr;
    logic [63:0] w_mtime_new;
    logic [31:0] w_off;
    logic [31:0] w_rdata;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    assign mem_req_rdy = !resp_vld_q || mem_resp_rdy;
    assign w_accept    = mem_req_vld && mem_req_rdy;
    assign w_wr        = w_accept && mem_req_wen;
    assign w_off       = 32'(mem_req_addr) & 32'hFFFF_FFFC;
    assign w_tick      = (pcnt_q == c_pcnt_max);

    // Single decode pass produces both the read value and the masked write effects.
    always_comb begin
        w_hit       = 1'b0;
        w_rdata     = '0;
        msip_d      = msip_q;
        mtimecmp_d  = mtimecmp_q;
        w_mtime_wr  = 1'b0;
        w_mtime_new = mtime_q;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_off == 32'(4 * h)) begin
                w_hit   = 1'b1;
                w_rdata = {31'b0, msip_q[h]};
                if (w_wr && mem_req_mask[0]) msip_d[h] = mem_req_data[0];
            end
            if (w_off == 32'(1024 + 8 * h)) begin
                w_hit   = 1'b1;
                w_rdata = mtimecmp_q[h][31:0];
                if (w_wr)
                    mtimecmp_d[h][31:0] = merge_bytes(mtimecmp_q[h][31:0], mem_req_data, mem_req_mask);
            end
            if (w_off == 32'(1028 + 8 * h)) begin
                w_hit   = 1'b1;
                w_rdata = mtimecmp_q[h][63:32];
                if (w_wr)
                    mtimecmp_d[h][63:32] = merge_bytes(mtimecmp_q[h][63:32], mem_req_data, mem_req_mask);
            end
        end
        if (w_off == 32'hFF8) begin
            w_hit   = 1'b1;
            w_rdata = mtime_q[31:0];
            if (w_wr && (mem_req_mask != 4'b0000)) begin
                w_mtime_wr         = 1'b1;
                w_mtime_new[31:0]  = merge_bytes(mtime_q[31:0], mem_req_data, mem_req_mask);
            end
        end
        if (w_off == 32'hFFC) begin
            w_hit   = 1'b1;
            w_rdata = mtime_q[63:32];
            if (w_wr && (mem_req_mask != 4'b0000)) begin
                w_mtime_wr         = 1'b1;
                w_mtime_new[63:32] = merge_bytes(mtime_q[63:32], mem_req_data, mem_req_mask);
            end
        end
    end

    // A software write to mtime swallows a coincident tick; the prescaler keeps running.
    always_comb begin
        pcnt_d  = w_tick ? '0 : pcnt_q + 1'b1;
        mtime_d = mtime_q;
        if (w_mtime_wr)  mtime_d = w_mtime_new;
        else if (w_tick) mtime_d = mtime_q + 64'd1;
        for (int h = 0; h < NUM_HARTS; h++) begin
            mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q      <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= '0;
            mtip_q      <= '0;
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            if (w_accept) begin
                resp_vld_q  <= 1'b1;
                resp_data_q <= mem_req_wen ? 32'd0 : w_rdata;
                resp_err_q  <= !w_hit;
            end else if (mem_resp_rdy) begin
                resp_vld_q  <= 1'b0;
            end
        end
    end

    assign mem_resp_vld  = resp_vld_q;
    assign mem_resp_data = resp_data_q;
    assign mem_resp_err  = resp_err_q;
    assign mtip          = mtip_q;
    assign msip          = msip_q;

endmodule
`default_nettype wire
